// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding, round constants and a computed S-box.
// The S-box is derived from the GF(2^8) inverse plus the affine map, so no table is stored.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_seq_state_e;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Rounds outside 1..10 only occur outside ROUND, where the key step is unused.
  function automatic logic [7:0] rcon_of(input logic [7:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (r == 8'(i)) v = RCON[i];
    end
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = xtime(t);
    end
    return r;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-expansion step: RotWord, SubWord, rcon, XOR chain.
// Zero latency; no flow control.
module aes_key_step (
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);
  import aes_pkg::*;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rot  = {w3[23:0], w3[31:24]};
  assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign temp = sub ^ {rcon, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES-128 sequencer; ciphertext valid 10 cycles after accept, one round per cycle.
// Holds output until out_ready; AES_SKID_OUT_EN adds an output buffer and stalls in ROUND when it is full.
module aes_round_seq #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic         busy
);
  import aes_pkg::*;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

  aes_seq_state_e   fsm_q, fsm_d;
  aes_block_t       blk_q, key_q, step_key;
  logic [RND_W-1:0] round_q;
  logic [7:0]       rcon;
  logic             accept, last, advance;

  assign rcon = rcon_of(8'(round_q));

  aes_key_step u_key_step (
    .key      (key_q),
    .rcon     (rcon),
    .next_key (step_key)
  );

  assign last     = (fsm_q == ROUND) && (round_q == LAST_RND);
  assign accept   = in_valid && in_ready;
  assign dp_state = blk_q;
  assign busy     = (fsm_q != IDLE);

`ifdef AES_SKID_OUT_EN
  aes_block_t obuf_q;
  logic       obuf_vld, pop, fill;

  // A pop in the same cycle frees the slot, so the new result may land immediately.
  assign pop     = obuf_vld && out_ready;
  assign fill    = last && (!obuf_vld || pop);
  assign advance = (fsm_q == ROUND) && (!last || fill);

  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_q   <= '0;
      obuf_vld <= 1'b0;
    end else if (fill) begin
      obuf_q   <= dp_result;
      obuf_vld <= 1'b1;
    end else if (pop) begin
      obuf_vld <= 1'b0;
    end
  end

  assign out_valid = obuf_vld;
  assign out_block = obuf_vld ? obuf_q : '0;
`else
  assign advance   = (fsm_q == ROUND);
  assign out_valid = (fsm_q == DONE);
  assign out_block = out_valid ? blk_q : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d    = fsm_q;
    in_ready = 1'b0;
    dp_key   = '0;
    dp_final = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) fsm_d = ROUND;
      end
      ROUND: begin
        dp_key   = step_key;
        dp_final = (round_q == LAST_RND);
`ifdef AES_SKID_OUT_EN
        if (fill) fsm_d = IDLE;
`else
        if (last) fsm_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q   <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else if (accept) begin
      blk_q   <= in_block ^ in_key;
      key_q   <= in_key;
      round_q <= RND_W'(1);
    end else if (advance) begin
      blk_q <= dp_result;
      key_q <= dp_key;
`ifdef AES_SKID_OUT_EN
      round_q <= last ? '0 : round_q + RND_W'(1);
`else
      round_q <= last ? round_q : round_q + RND_W'(1);
`endif
    end else if (fsm_q == DONE && out_ready) begin
      round_q <= '0;
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq with a behavioural round datapath and a ciphertext scoreboard.
module tb_aes_round_seq;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_SKID_OUT_EN
  localparam int   GAP      = 11;
  localparam logic HOLD_RDY = 1'b1;
`else
  localparam int   GAP      = 12;
  localparam logic HOLD_RDY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_block;
  logic [127:0] dp_state, dp_key, dp_result;
  logic         dp_final;
  logic         busy;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic         lat_en = 1'b1;
  logic         prev_ov = 1'b0;
  logic [127:0] in_exp = '0;
  logic [127:0] sb[$];
  int           acc_q[$];
  int           acc_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_seq #(.NUM_ROUNDS(10), .RND_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .dp_state  (dp_state),
    .dp_key    (dp_key),
    .dp_final  (dp_final),
    .dp_result (dp_result),
    .busy      (busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey; byte i = row (i%4), column (i/4).
  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k,
                                           input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[rw+4*c] = b[rw+4*((c+rw)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i] ^ k[127-8*i -: 8];
    return r;
  endfunction

  always_comb dp_result = aes_rnd(dp_state, dp_key, dp_final);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accepts push the expected ciphertext; output handshakes pop and compare it.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(in_exp);
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
      end
      if (out_valid && !prev_ov && lat_en && acc_q.size() > 0)
        chk("latency", 128'(cyc - acc_q[0] - 1), 128'd10);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 128'(out_valid), 128'd0);
        else begin
          chk("ciphertext", out_block, sb.pop_front());
          if (acc_q.size() > 0) void'(acc_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_rdy();
    int n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    chk("accept_timeout", 128'(in_ready), 128'd1);
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    in_block = pt;
    in_key   = key;
    in_exp   = exp;
    in_valid = 1'b1;
    wait_rdy();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    chk("out_timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic drain();
    int n = 0;
    do begin @(posedge clk); #2; n++; end while ((sb.size() != 0 || busy || out_valid) && n < 200);
    chk("drain_timeout", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dp_final", 128'(dp_final), 128'd0);
    chk("rst_dp_key", dp_key, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;

    send(C1_PT, C1_KEY, C1_CT);
    drain();
    send(B_PT, B_KEY, B_CT);
    drain();

    out_ready = 1'b0;
    send(C1_PT, C1_KEY, C1_CT);
    wait_ov();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid), 128'd1);
      chk("hold_out_block", out_block, C1_CT);
      chk("hold_in_ready", 128'(in_ready), 128'(HOLD_RDY));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", 128'(out_valid), 128'd0);
    chk("release_busy", 128'(busy), 128'd0);
    chk("release_in_ready", 128'(in_ready), 128'd1);
    drain();

    send(C1_PT, C1_KEY, C1_CT);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    send(C1_PT, C1_KEY, C1_CT);
    drain();

    in_block = C1_PT; in_key = C1_KEY; in_exp = C1_CT; in_valid = 1'b1;
    wait_rdy();
    @(posedge clk); #1;
    in_block = B_PT; in_key = B_KEY; in_exp = B_CT;
    wait_rdy();
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    if (acc_log.size() >= 2) chk("issue_gap", 128'(acc_log[$] - acc_log[$-1]), 128'(GAP));
    else chk("issue_gap_count", 128'(acc_log.size()), 128'd2);

`ifdef AES_SKID_OUT_EN
    lat_en = 1'b0;
    out_ready = 1'b0;
    send(C1_PT, C1_KEY, C1_CT);
    send(B_PT, B_KEY, B_CT);
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("stall_busy", 128'(busy), 128'd1);
    chk("stall_out_valid", 128'(out_valid), 128'd1);
    chk("stall_out_block", out_block, C1_CT);
    chk("stall_dp_final", 128'(dp_final), 128'd1);
    chk("stall_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    lat_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
